ccff_chain_loader: RTL and testbench

- Drives a configuration-chain (ccff) shift register from the programming side.
- Accepts bitstream words from a host over a valid/ready interface, serializes them onto ccff_head, and gates shifting of the downstream chain with a clock-enable.
- Sits between the bitstream source and the first ccff_head of the fabric's tile chain.
- The last chain ccff_tail returns to this block.

---
 rtl/ccff_pkg.sv | 23 ++
 rtl/ccff_crc16_serial.sv | 27 ++
 rtl/ccff_chain_loader.sv | 186 ++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types and CRC helpers for the ccff chain loader.
// The CRC pieces are used only when CCFF_READBACK_VERIFY_EN is defined.
package ccff_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      VERIFY,
      DONE
   } state_t;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // One serial CRC-16-CCITT step, MSB-first feedback.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic dataBit);
      logic fb;
      fb = crc[15] ^ dataBit;
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear and enable.
module ccff_crc16_serial
   import ccff_pkg::*;
(
   input  logic        prog_clk,
   input  logic        prog_reset,
   input  logic        i_clear,
   input  logic        i_en,
   input  logic        i_bit,
   output logic [15:0] o_crc
);

   logic [15:0] r_crc;

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         r_crc <= CRC16_INIT;
      end else if (i_clear) begin
         r_crc <= CRC16_INIT;
      end else if (i_en) begin
         r_crc <= crc16_step(r_crc, i_bit);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host bitstream words onto a ccff configuration chain.
// Define CCFF_READBACK_VERIFY_EN to add a CRC readback pass over the chain.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int CHAIN_LEN = 6,
   parameter int WORD_W    = 4,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic [WORD_W-1:0] cfg_word,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   state_t            r_state;
   logic [WORD_W-1:0] r_sreg;
   logic [CNT_W-1:0]  r_bitsLeft;
   logic [CNT_W-1:0]  r_n;
   logic              r_ready;
   logic              r_head;
   logic              r_shiftEn;
   logic              r_busy;
   logic              r_done;
   logic [CNT_W-1:0]  w_firstN;

   // A short final word only shifts the bits still owed to the chain.
   always_comb begin
      if (int'(r_bitsLeft) > WORD_W) w_firstN = CNT_W'(WORD_W);
      else                           w_firstN = r_bitsLeft;
   end

`ifdef CCFF_READBACK_VERIFY_EN
   logic        r_err;
   logic [15:0] w_headCrc;
   logic [15:0] w_tailCrc;
   logic [15:0] w_tailCrcFinal;
   logic        w_crcClear;
   logic        w_headCrcEn;
   logic        w_tailCrcEn;

   assign w_crcClear     = (r_state == IDLE) && cfg_start;
   assign w_headCrcEn    = (r_state == SHIFT);
   assign w_tailCrcEn    = (r_state == VERIFY);
   assign w_tailCrcFinal = crc16_step(w_tailCrc, ccff_tail);

   ccff_crc16_serial u_headCrc (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .i_clear    (w_crcClear),
      .i_en       (w_headCrcEn),
      .i_bit      (r_head),
      .o_crc      (w_headCrc)
   );

   ccff_crc16_serial u_tailCrc (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .i_clear    (w_crcClear),
      .i_en       (w_tailCrcEn),
      .i_bit      (ccff_tail),
      .o_crc      (w_tailCrc)
   );

   // Recirculating the tail during readback keeps the chain contents intact.
   assign ccff_head = (r_state == VERIFY) ? ccff_tail : r_head;
   assign err       = r_err;
`else
   logic w_unusedTail;
   assign w_unusedTail = ccff_tail;
   assign ccff_head    = r_head;
   assign err          = 1'b0;
`endif

   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         r_state    <= IDLE;
         r_sreg     <= '0;
         r_bitsLeft <= '0;
         r_n        <= '0;
         r_ready    <= 1'b0;
         r_head     <= 1'b0;
         r_shiftEn  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef CCFF_READBACK_VERIFY_EN
         r_err      <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (cfg_abort && (r_state != IDLE)) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_head    <= 1'b0;
            r_shiftEn <= 1'b0;
            r_busy    <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (cfg_start) begin
                     r_state    <= LOAD;
                     r_bitsLeft <= LEN_CNT;
                     r_ready    <= 1'b1;
                     r_busy     <= 1'b1;
`ifdef CCFF_READBACK_VERIFY_EN
                     r_err      <= 1'b0;
`endif
                  end
               end
               LOAD: begin
                  if (cfg_valid && r_ready) begin
                     r_state   <= SHIFT;
                     r_head    <= cfg_word[0];
                     r_sreg    <= cfg_word >> 1;
                     r_n       <= w_firstN;
                     r_ready   <= 1'b0;
                     r_shiftEn <= 1'b1;
                  end
               end
               SHIFT: begin
                  r_head     <= r_sreg[0];
                  r_sreg     <= r_sreg >> 1;
                  r_bitsLeft <= r_bitsLeft - ONE_CNT;
                  r_n        <= r_n - ONE_CNT;
                  if (r_n == ONE_CNT) begin
                     r_head <= 1'b0;
                     if (r_bitsLeft != ONE_CNT) begin
                        r_state   <= LOAD;
                        r_ready   <= 1'b1;
                        r_shiftEn <= 1'b0;
                     end else begin
`ifdef CCFF_READBACK_VERIFY_EN
                        r_state <= VERIFY;
                        r_n     <= LEN_CNT;
`else
                        r_state   <= DONE;
                        r_shiftEn <= 1'b0;
                        r_done    <= 1'b1;
`endif
                     end
                  end
               end
`ifdef CCFF_READBACK_VERIFY_EN
               VERIFY: begin
                  r_n <= r_n - ONE_CNT;
                  if (r_n == ONE_CNT) begin
                     r_state   <= DONE;
                     r_shiftEn <= 1'b0;
                     if (w_headCrc != w_tailCrcFinal) r_err  <= 1'b1;
                     else                             r_done <= 1'b1;
                  end
               end
`endif
               DONE: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state   <= IDLE;
                  r_ready   <= 1'b0;
                  r_shiftEn <= 1'b0;
                  r_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cfg_ready     = r_ready;
   assign ccff_shift_en = r_shiftEn;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader with a behavioural chain model.
// Expectations follow CCFF_READBACK_VERIFY_EN when it is defined.
module tb_ccff_chain_loader;

   localparam int CHAIN_LEN = 6;
   localparam int WORD_W    = 4;
   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef CCFF_READBACK_VERIFY_EN
   localparam int VERIFY_CYC = CHAIN_LEN;
`else
   localparam int VERIFY_CYC = 0;
`endif

   logic              prog_clk = 1'b0;
   logic              prog_reset;
   logic              cfg_start;
   logic              cfg_abort;
   logic [WORD_W-1:0] cfg_word;
   logic              cfg_valid;
   logic              cfg_ready;
   logic              ccff_head;
   logic              ccff_shift_en;
   logic              ccff_tail;
   logic              busy;
   logic              done;
   logic              err;

   int passCount  = 0;
   int checkCount = 0;

   logic [CHAIN_LEN-1:0] chain;
   logic [CHAIN_LEN-1:0] chainNext;
   logic                 faultCell2 = 1'b0;
   logic [WORD_W-1:0]    curWords [NWORDS];

   int          doneCount, doneAt, readyCycles, nHead, overlap;
   logic        endBusy, endShift, timedOut, errAfterStart;
   logic [63:0] obsSeq;

   ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
      .prog_clk      (prog_clk),
      .prog_reset    (prog_reset),
      .cfg_start     (cfg_start),
      .cfg_abort     (cfg_abort),
      .cfg_word      (cfg_word),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   always #5 prog_clk = ~prog_clk;

   // Chain of CHAIN_LEN cells; faultCell2 inverts the value leaving cell 2.
   always @(posedge prog_clk) begin
      if (ccff_shift_en) begin
         chainNext = {ccff_head, chain[CHAIN_LEN-1:1]};
         if (faultCell2) chainNext[1] = ~chainNext[1];
         chain <= chainNext;
      end
   end
   assign ccff_tail = chain[0];

   // Bit i of the load (bit 0 shifted first) ends up in chain cell i.
   function automatic logic [CHAIN_LEN-1:0] modelSeq();
      logic [CHAIN_LEN-1:0] s;
      s = '0;
      for (int i = 0; i < CHAIN_LEN; i++) s[i] = curWords[i / WORD_W][i % WORD_W];
      return s;
   endfunction

   // Edges from the start-sampling edge until DONE is entered.
   function automatic int expCycles(input int stall);
      int left, c, n;
      left = CHAIN_LEN;
      c = 0;
      while (left > 0) begin
         n = (left < WORD_W) ? left : WORD_W;
         c += 1 + n;
         left -= n;
      end
      return c + VERIFY_CYC + 1 + stall;
   endfunction

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic applyStimulus(input int stall, input int abortAt, input int startAt);
      int  wordIdx, stallLeft;
      logic hs;
      doneCount = 0; doneAt = -1; readyCycles = 0; nHead = 0; overlap = 0;
      obsSeq = '0; timedOut = 1'b0; endBusy = 1'b1; endShift = 1'b1;
      cfg_valid = 1'b1;
      cfg_word  = WORD_W'($urandom);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      wordIdx   = 0;
      stallLeft = stall;
      for (int k = 1; k <= 200; k++) begin
         if (k == 1) errAfterStart = err;
         if (done) begin
            doneCount++;
            if (doneAt < 0) doneAt = k;
         end
         if (cfg_ready) readyCycles++;
         if (cfg_ready && ccff_shift_en) overlap++;
         if (ccff_shift_en) begin
            if (nHead < 64) obsSeq[nHead] = ccff_head;
            nHead++;
         end
         if (!busy) begin
            endBusy  = busy;
            endShift = ccff_shift_en;
            break;
         end
         if (stallLeft > 0 && cfg_ready) begin
            cfg_valid = 1'b0;
            stallLeft--;
         end else begin
            cfg_valid = 1'b1;
         end
         cfg_word  = (wordIdx < NWORDS) ? curWords[wordIdx] : WORD_W'($urandom);
         hs        = cfg_valid && cfg_ready;
         cfg_abort = (k == abortAt);
         cfg_start = (k == startAt);
         tick();
         if (hs) wordIdx++;
         if (k == 200) timedOut = 1'b1;
      end
      cfg_abort = 1'b0;
      cfg_start = 1'b0;
   endtask

   task automatic test_reset();
      prog_reset = 1'b1;
      cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_word = '0;
      chain = '0;
      tick(); tick();
      checkCount++; if (cfg_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b want 0", cfg_ready); else passCount++;
      checkCount++; if (ccff_head !== 1'b0) $display("[TB] FAIL reset_head: got %b want 0", ccff_head); else passCount++;
      checkCount++; if (ccff_shift_en !== 1'b0) $display("[TB] FAIL reset_shift_en: got %b want 0", ccff_shift_en); else passCount++;
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
      checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else passCount++;
      checkCount++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err); else passCount++;
      prog_reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_load();
      curWords[0] = 4'hA;
      curWords[1] = 4'h3;
      applyStimulus(0, -1, -1);
      checkCount++; if (timedOut) $display("[TB] FAIL basic_timeout: got busy after 200 cycles want idle"); else passCount++;
      checkCount++; if (obsSeq[CHAIN_LEN-1:0] !== 6'b111010) $display("[TB] FAIL basic_head_seq: got %b want 111010", obsSeq[CHAIN_LEN-1:0]); else passCount++;
      checkCount++; if (nHead != CHAIN_LEN + VERIFY_CYC) $display("[TB] FAIL basic_shift_count: got %0d want %0d", nHead, CHAIN_LEN + VERIFY_CYC); else passCount++;
      checkCount++; if (readyCycles != NWORDS) $display("[TB] FAIL basic_ready_cycles: got %0d want %0d", readyCycles, NWORDS); else passCount++;
      checkCount++; if (doneCount != 1) $display("[TB] FAIL basic_done_count: got %0d want 1", doneCount); else passCount++;
      checkCount++; if (doneAt != expCycles(0)) $display("[TB] FAIL basic_done_time: got %0d want %0d", doneAt, expCycles(0)); else passCount++;
      checkCount++; if (chain !== modelSeq()) $display("[TB] FAIL basic_chain: got %b want %b", chain, modelSeq()); else passCount++;
      checkCount++; if (err !== 1'b0) $display("[TB] FAIL basic_err: got %b want 0", err); else passCount++;
   endtask

   task automatic test_stall();
      curWords[0] = 4'hA;
      curWords[1] = 4'h3;
      applyStimulus(5, -1, -1);
      checkCount++; if (overlap != 0) $display("[TB] FAIL stall_shift_in_load: got %0d overlapping cycles want 0", overlap); else passCount++;
      checkCount++; if (readyCycles != NWORDS + 5) $display("[TB] FAIL stall_ready_cycles: got %0d want %0d", readyCycles, NWORDS + 5); else passCount++;
      checkCount++; if (doneAt != expCycles(5)) $display("[TB] FAIL stall_done_time: got %0d want %0d", doneAt, expCycles(5)); else passCount++;
      checkCount++; if (chain !== modelSeq()) $display("[TB] FAIL stall_chain: got %b want %b", chain, modelSeq()); else passCount++;
   endtask

   task automatic test_random_loads();
      int stall;
      for (int it = 0; it < 6; it++) begin
         for (int w = 0; w < NWORDS; w++) curWords[w] = WORD_W'($urandom);
         stall = $urandom_range(0, 3);
         applyStimulus(stall, -1, -1);
         checkCount++; if (obsSeq[CHAIN_LEN-1:0] !== modelSeq()) $display("[TB] FAIL rand_head_seq[%0d]: got %b want %b", it, obsSeq[CHAIN_LEN-1:0], modelSeq()); else passCount++;
         checkCount++; if (chain !== modelSeq()) $display("[TB] FAIL rand_chain[%0d]: got %b want %b", it, chain, modelSeq()); else passCount++;
         checkCount++; if (doneCount != 1 || doneAt != expCycles(stall)) $display("[TB] FAIL rand_done[%0d]: got count %0d at %0d want 1 at %0d", it, doneCount, doneAt, expCycles(stall)); else passCount++;
      end
   endtask

   task automatic test_abort();
      curWords[0] = 4'h5;
      curWords[1] = 4'hC;
      applyStimulus(0, 3, -1);
      checkCount++; if (endBusy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", endBusy); else passCount++;
      checkCount++; if (endShift !== 1'b0) $display("[TB] FAIL abort_shift_en: got %b want 0", endShift); else passCount++;
      checkCount++; if (nHead != 2) $display("[TB] FAIL abort_shift_count: got %0d want 2", nHead); else passCount++;
      checkCount++; if (doneCount != 0) $display("[TB] FAIL abort_done: got %0d pulses want 0", doneCount); else passCount++;
      curWords[0] = 4'h9;
      curWords[1] = 4'h2;
      applyStimulus(0, -1, -1);
      checkCount++; if (chain !== modelSeq() || doneCount != 1) $display("[TB] FAIL abort_reload: got chain %b done %0d want %b done 1", chain, doneCount, modelSeq()); else passCount++;
   endtask

   task automatic test_async_reset();
      curWords[0] = 4'hF;
      curWords[1] = 4'hF;
      cfg_valid = 1'b1;
      cfg_word  = curWords[0];
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      tick();
      tick();
      #2;
      prog_reset = 1'b1;
      #1;
      checkCount++; if ({busy, ccff_shift_en, cfg_ready, ccff_head, done} !== 5'b0) $display("[TB] FAIL async_reset_outputs: got %b want 00000", {busy, ccff_shift_en, cfg_ready, ccff_head, done}); else passCount++;
      #2;
      prog_reset = 1'b0;
      cfg_valid = 1'b0;
      tick();
      checkCount++; if (busy !== 1'b0) $display("[TB] FAIL async_reset_idle: got busy %b want 0", busy); else passCount++;
   endtask

   task automatic test_start_while_busy();
      int startAts [3];
      startAts[0] = 3;
      startAts[1] = 6;
      startAts[2] = expCycles(0);
      for (int i = 0; i < 3; i++) begin
         curWords[0] = WORD_W'($urandom);
         curWords[1] = WORD_W'($urandom);
         applyStimulus(0, -1, startAts[i]);
         checkCount++; if (doneCount != 1 || doneAt != expCycles(0)) $display("[TB] FAIL busy_start_done[%0d]: got count %0d at %0d want 1 at %0d", i, doneCount, doneAt, expCycles(0)); else passCount++;
         checkCount++; if (obsSeq[CHAIN_LEN-1:0] !== modelSeq()) $display("[TB] FAIL busy_start_seq[%0d]: got %b want %b", i, obsSeq[CHAIN_LEN-1:0], modelSeq()); else passCount++;
         tick();
         checkCount++; if (busy !== 1'b0) $display("[TB] FAIL busy_start_idle[%0d]: got %b want 0", i, busy); else passCount++;
      end
   endtask

   task automatic test_verify_fault();
      curWords[0] = 4'hA;
      curWords[1] = 4'h3;
      faultCell2 = 1'b1;
      applyStimulus(0, -1, -1);
`ifdef CCFF_READBACK_VERIFY_EN
      checkCount++; if (err !== 1'b1) $display("[TB] FAIL fault_err: got %b want 1", err); else passCount++;
      checkCount++; if (doneCount != 0) $display("[TB] FAIL fault_done: got %0d pulses want 0", doneCount); else passCount++;
      tick(); tick(); tick();
      checkCount++; if (err !== 1'b1) $display("[TB] FAIL fault_err_sticky: got %b want 1", err); else passCount++;
`else
      checkCount++; if (err !== 1'b0 || doneCount != 1) $display("[TB] FAIL fault_no_verify: got err %b done %0d want err 0 done 1", err, doneCount); else passCount++;
`endif
      faultCell2 = 1'b0;
      applyStimulus(0, -1, -1);
      checkCount++; if (errAfterStart !== 1'b0) $display("[TB] FAIL fault_err_cleared: got %b want 0", errAfterStart); else passCount++;
      checkCount++; if (err !== 1'b0 || doneCount != 1) $display("[TB] FAIL fault_recover: got err %b done %0d want err 0 done 1", err, doneCount); else passCount++;
      checkCount++; if (chain !== modelSeq()) $display("[TB] FAIL fault_recover_chain: got %b want %b", chain, modelSeq()); else passCount++;
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_stall();
      test_random_loads();
      test_abort();
      test_async_reset();
      test_start_while_busy();
      test_verify_fault();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
